rot_fetch_sched: RTL

Scheduler for the bilinear-interpolation fetch path of the image rotation pipeline. It accepts per-pixel source coordinates from the inverse-rotation coordinate generator and issues one neighbour-quad read per pixel to the frame-buffer fetch unit. It drives the write and read strobes of the fractional-coefficient FIFO so that each (fx, fy) pair leaves the FIFO in the same cycle its four neighbour pixels return. It also bounds the number of outstanding fetches and sequences pixels into lines and frames with a fixed inter-line gap.

---
 rtl/rot_fetch_sched.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rot_fetch_sched.sv
// -----------------------------------------------------------------------------
// rot_fetch_sched
//
// Fetch scheduler for the bilinear-interpolation path of the image rotation
// pipeline. For each source coordinate from the inverse-rotation generator it
// issues one neighbour-quad read to the frame-buffer fetch unit. It strobes the
// fractional-coefficient FIFO so that each (fx, fy) pair is written when the
// pixel is accepted and read in the cycle its neighbour quad returns. It also
// bounds the number of outstanding fetches and sequences pixels into lines and
// frames, with a fixed idle gap between lines.
//
// Ports
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_fsyn                frame-start pulse (only honoured in IDLE)
//   i_coord_vld/o_coord_rdy, iv_x/iv_y
//                         coordinate handshake; integer top-left neighbour
//   o_rd_req, ov_rd_x/ov_rd_y, i_rd_gnt
//                         neighbour-quad fetch request, held until granted
//   i_nbr_vld             neighbour quad returned (in request order)
//   o_fxy_wr, o_fxy_rd    coefficient FIFO write / read strobes
//   ov_col, ov_row        current column and line counters
//   o_line_done, o_frame_done
//                         one-cycle pulses in the cycle a line drain completes
//   o_busy                high whenever the scheduler is not IDLE
//   o_err                 sticky protocol-error flag
// -----------------------------------------------------------------------------
module rot_fetch_sched #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MAX_OUT  = 16,
    parameter int HGAP     = 8,
    parameter int CW       = 11
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_fsyn,
    input  logic          i_coord_vld,
    output logic          o_coord_rdy,
    input  logic [CW-1:0] iv_x,
    input  logic [CW-1:0] iv_y,
    output logic          o_rd_req,
    output logic [CW-1:0] ov_rd_x,
    output logic [CW-1:0] ov_rd_y,
    input  logic          i_rd_gnt,
    input  logic          i_nbr_vld,
    output logic          o_fxy_wr,
    output logic          o_fxy_rd,
    output logic [CW-1:0] ov_col,
    output logic [CW-1:0] ov_row,
    output logic          o_line_done,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_err
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int GW = (HGAP > 1) ? $clog2(HGAP) : 1;

    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);
    localparam logic [OW-1:0] OUT_ONE  = OW'(1);
    localparam logic [OW-1:0] OUT_ZERO = OW'(0);
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [GW-1:0] GAP_LAST = GW'(HGAP - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [GW-1:0] GAP_ZERO = GW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_GAP   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          rd_req_q, rd_req_d;
    logic [CW-1:0] rd_x_q, rd_x_d;
    logic [CW-1:0] rd_y_q, rd_y_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          line_done_q, line_done_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          rdy_s;
    logic          accept_s;
    logic          ret_s;
    logic          drain_exit_s;

    // Handshake decode: acceptance, valid returns and the drain-complete condition.
    always_comb begin
        rdy_s        = (state_q == ST_RUN) && (outst_q < OUT_MAX) && (!rd_req_q || i_rd_gnt);
        accept_s     = i_coord_vld && rdy_s;
        // A return with nothing outstanding is a protocol error and is dropped.
        ret_s        = i_nbr_vld && (outst_q != OUT_ZERO);
        drain_exit_s = (state_q == ST_DRAIN) && (outst_q == OUT_ZERO) && !rd_req_q;
    end

    // Next-state logic for the FSM, counters, fetch request and status flags.
    always_comb begin
        state_d      = state_q;
        outst_d      = outst_q;
        rd_req_d     = rd_req_q;
        rd_x_d       = rd_x_q;
        rd_y_d       = rd_y_q;
        col_d        = col_q;
        row_d        = row_q;
        gap_d        = gap_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                col_d = CNT_ZERO;
                row_d = CNT_ZERO;
                if (i_fsyn) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (col_q == COL_LAST) begin
                        col_d   = CNT_ZERO;
                        state_d = ST_DRAIN;
                    end else begin
                        col_d   = col_q + CNT_ONE;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_exit_s) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = CNT_ZERO;
                        state_d = ST_IDLE;
                    end else begin
                        row_d   = row_q + CNT_ONE;
                        gap_d   = GAP_ZERO;
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    gap_d   = gap_q + GAP_ONE;
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outstanding count: accept and return in the same cycle cancel out.
        // Acceptance is gated by outst < MAX_OUT and returns by outst != 0,
        // so the counter can never wrap.
        case ({accept_s, ret_s})
            2'b10:   outst_d = outst_q + OUT_ONE;
            2'b01:   outst_d = outst_q - OUT_ONE;
            default: outst_d = outst_q;
        endcase

        // A new accept re-arms the request even when the old one is granted
        // in the same cycle; otherwise a grant retires it.
        if (accept_s) begin
            rd_req_d = 1'b1;
            rd_x_d   = iv_x;
            rd_y_d   = iv_y;
        end else if (i_rd_gnt) begin
            rd_req_d = 1'b0;
        end else begin
            rd_req_d = rd_req_q;
        end

        if ((i_fsyn && (state_q != ST_IDLE)) || (i_nbr_vld && (outst_q == OUT_ZERO))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        // The done pulses are registered but computed from next-state values,
        // so they are high in exactly the cycle the DRAIN exit condition holds.
        line_done_d  = (state_d == ST_DRAIN) && (outst_d == OUT_ZERO) && !rd_req_d;
        frame_done_d = line_done_d && (row_d == ROW_LAST);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            outst_q      <= OUT_ZERO;
            rd_req_q     <= 1'b0;
            rd_x_q       <= CNT_ZERO;
            rd_y_q       <= CNT_ZERO;
            col_q        <= CNT_ZERO;
            row_q        <= CNT_ZERO;
            gap_q        <= GAP_ZERO;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            outst_q      <= outst_d;
            rd_req_q     <= rd_req_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            col_q        <= col_d;
            row_q        <= row_d;
            gap_q        <= gap_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Output mapping; the handshake strobes are combinational by design.
    always_comb begin
        o_coord_rdy  = rdy_s;
        o_fxy_wr     = accept_s;
        o_fxy_rd     = ret_s;
        o_rd_req     = rd_req_q;
        ov_rd_x      = rd_x_q;
        ov_rd_y      = rd_y_q;
        ov_col       = col_q;
        ov_row       = row_q;
        o_line_done  = line_done_q;
        o_frame_done = frame_done_q;
        o_busy       = busy_q;
        o_err        = err_q;
    end

endmodule
